// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the RV32M multiply/divide sequencer.
package mdu_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } mdop_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIN  = 2'b10
  } state_t;

  function automatic logic is_div(input mdop_t op);
    case (op)
      DIV, DIVU, REM, REMU: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic is_rem(input mdop_t op);
    case (op)
      REM, REMU: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_a(input mdop_t op);
    case (op)
      MUL, MULH, MULHSU, DIV, REM: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_b(input mdop_t op);
    case (op)
      MUL, MULH, DIV, REM: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// One radix-2 step on unsigned magnitudes: shift-add multiply or restoring divide.
module mdu_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   operand,
  input  logic                    div_mode,
  output logic [2*DATA_WIDTH-1:0] acc_nxt
);

  localparam int W = DATA_WIDTH;

  logic [W:0] add_s;
  logic [W:0] trial_s;
  logic [W:0] diff_s;

  // acc is {product_hi, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    add_s   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : {(W+1){1'b0}});
    trial_s = acc[2*W-1:W-1];
    diff_s  = trial_s - {1'b0, operand};
    if (div_mode) begin
      if (diff_s[W] == 1'b0) begin
        acc_nxt = {diff_s[W-1:0], acc[W-2:0], 1'b1};
      end else begin
        acc_nxt = {acc[2*W-2:0], 1'b0};
      end
    end else begin
      acc_nxt = {add_s, acc[W-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle RV32M multiply/divide sequencer beside the EX-stage ALU.
// Define MDU_FAST_MUL_EN to compute all MUL* ops in a single cycle.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            mdop,
  input  logic [DATA_WIDTH-1:0] opr_a,
  input  logic [DATA_WIDTH-1:0] opr_b,
  input  logic                  flush,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]     MIN_NEG  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]     ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0]     ZERO_W   = {W{1'b0}};

  state_t           state_r;
  mdop_t            op_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2*W-1:0]   acc_r;
  logic [W-1:0]     opnd_r;
  logic             neg_r;
  logic             done_r;
  logic [W-1:0]     result_r;

  mdop_t          op_s;
  logic           a_neg_s;
  logic           b_neg_s;
  logic [W-1:0]   a_mag_s;
  logic [W-1:0]   b_mag_s;
  logic           special_s;
  logic [W-1:0]   special_res_s;
  logic           neg_s;
  logic [2*W-1:0] acc_init_s;
  logic [W-1:0]   opnd_init_s;
  logic [2*W-1:0] acc_nxt_s;
  logic [2*W-1:0] prod_s;
  logic [W-1:0]   quo_s;
  logic [W-1:0]   rem_s;
  logic [W-1:0]   fin_res_s;

  assign op_s = mdop_t'(mdop);

  // Issue-time decode: magnitudes, sign of the final result, divide corner cases
  always_comb begin
    a_neg_s = is_signed_a(op_s) & opr_a[W-1];
    b_neg_s = is_signed_b(op_s) & opr_b[W-1];
    a_mag_s = a_neg_s ? -opr_a : opr_a;
    b_mag_s = b_neg_s ? -opr_b : opr_b;
    neg_s   = is_rem(op_s) ? a_neg_s : (a_neg_s ^ b_neg_s);
    special_s     = 1'b0;
    special_res_s = ZERO_W;
    if (is_div(op_s) && (opr_b == ZERO_W)) begin
      special_s     = 1'b1;
      special_res_s = is_rem(op_s) ? opr_a : ALL_ONES;
    end else if (((op_s == DIV) || (op_s == REM)) && (opr_a == MIN_NEG) && (opr_b == ALL_ONES)) begin
      special_s     = 1'b1;
      special_res_s = is_rem(op_s) ? ZERO_W : opr_a;
    end else begin
      special_s     = 1'b0;
      special_res_s = ZERO_W;
    end
    if (is_div(op_s)) begin
      acc_init_s  = {ZERO_W, a_mag_s};
      opnd_init_s = b_mag_s;
    end else begin
      acc_init_s  = {ZERO_W, b_mag_s};
      opnd_init_s = a_mag_s;
    end
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*W-1:0] fast_prod_s;
  logic [W-1:0]   fast_res_s;

  // Sign-extending by the decoded sign bit makes the truncated product exact for every MUL* form
  always_comb begin
    fast_prod_s = {{W{a_neg_s}}, opr_a} * {{W{b_neg_s}}, opr_b};
    if (op_s == MUL) begin
      fast_res_s = fast_prod_s[W-1:0];
    end else begin
      fast_res_s = fast_prod_s[2*W-1:W];
    end
  end
`endif

  mdu_iter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_iter (
    .acc      (acc_r),
    .operand  (opnd_r),
    .div_mode (is_div(op_r)),
    .acc_nxt  (acc_nxt_s)
  );

  // Sign fixup of the final step's output, captured into result_r on entry to FIN
  always_comb begin
    prod_s = neg_r ? -acc_nxt_s : acc_nxt_s;
    quo_s  = neg_r ? -acc_nxt_s[W-1:0] : acc_nxt_s[W-1:0];
    rem_s  = neg_r ? -acc_nxt_s[2*W-1:W] : acc_nxt_s[2*W-1:W];
    if (is_div(op_r)) begin
      fin_res_s = is_rem(op_r) ? rem_s : quo_s;
    end else if (op_r == MUL) begin
      fin_res_s = prod_s[W-1:0];
    end else begin
      fin_res_s = prod_s[2*W-1:W];
    end
  end

  // stall must rise in the issuing cycle, so it is decoded from state and inputs
  always_comb begin
    case (state_r)
      IDLE:    stall = start & ~flush;
      CALC:    stall = ~flush;
      default: stall = 1'b0;
    endcase
  end

  assign done   = done_r & ~flush;
  assign result = result_r;

  // Sequencer FSM; flush abandons any op in flight without producing a result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      op_r     <= MUL;
      cnt_r    <= {CNT_W{1'b0}};
      acc_r    <= {(2*W){1'b0}};
      opnd_r   <= ZERO_W;
      neg_r    <= 1'b0;
      done_r   <= 1'b0;
      result_r <= ZERO_W;
    end else if (flush) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            op_r  <= op_s;
            neg_r <= neg_s;
            cnt_r <= {CNT_W{1'b0}};
            if (special_s) begin
              state_r  <= FIN;
              done_r   <= 1'b1;
              result_r <= special_res_s;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!is_div(op_s)) begin
              state_r  <= FIN;
              done_r   <= 1'b1;
              result_r <= fast_res_s;
            end
`endif
            else begin
              state_r <= CALC;
              acc_r   <= acc_init_s;
              opnd_r  <= opnd_init_s;
            end
          end
        end
        CALC: begin
          acc_r <= acc_nxt_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r  <= FIN;
            done_r   <= 1'b1;
            result_r <= fin_res_s;
          end
        end
        FIN: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus random ops against an arithmetic model.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] opr_a;
  logic [31:0] opr_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_res;

  mdu_seq #(.DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mdop   (mdop),
    .opr_a  (opr_a),
    .opr_b  (opr_b),
    .flush  (flush),
    .stall  (stall),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M semantics straight from the ISA rules, in 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, pu;
    logic [31:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 32'd0;
    case (op)
      3'd0: begin p = sa * sb;           r = p[31:0];  end
      3'd1: begin p = sa * sb;           r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin pu = ua * ub;          r = pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'd5: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin pu = ua / ub; r = pu[31:0]; end
      end
      3'd6: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) r = a;
        else begin pu = ua % ub; r = pu[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    lat = 33;
    if (op[2]) begin
      if (b == 32'd0) lat = 1;
      else if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) lat = 1;
    end else begin
`ifdef MDU_FAST_MUL_EN
      lat = 1;
`else
      lat = 33;
`endif
    end
    return lat;
  endfunction

  // Issue one op in an IDLE cycle, follow it to done, and leave the DUT in IDLE
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp_res;
    int          exp_lat;
    int          lat;
    int          n_st;
    logic        seen;
    exp_res = ref_model(op, a, b);
    exp_lat = ref_latency(op, a, b);
    mdop  = op;
    opr_a = a;
    opr_b = b;
    start = 1'b1;
    #1;
    chk({tag, "/issue_stall"}, 32'(stall), 32'd1);
    n_st = 1;
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= 64 && !seen; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      mdop  = 3'($urandom_range(0, 7));
      opr_a = $urandom;
      opr_b = $urandom;
      #1;
      if (done) begin
        seen     = 1'b1;
        lat      = c;
        last_res = result;
        chk({tag, "/result"}, result, exp_res);
        chk({tag, "/done_stall"}, 32'(stall), 32'd0);
      end else if (stall) begin
        n_st++;
      end
    end
    chk({tag, "/done_seen"}, 32'(seen), 32'd1);
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/stall_cycles"}, 32'(n_st), 32'(exp_lat));
    @(posedge clk);
    #1;
    chk({tag, "/done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    int n_st;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    mdop  = 3'd0;
    opr_a = 32'd0;
    opr_b = 32'd0;
    #2;
    chk("reset/stall", 32'(stall), 32'd0);
    chk("reset/done", 32'(done), 32'd0);
    chk("reset/result", result, 32'd0);
    #20;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul_7_m3");
    chk("mul_7_m3/const", last_res, 32'hFFFF_FFEB);
    run_op(3'd5, 32'd100, 32'd7, "divu_100_7");
    chk("divu_100_7/const", last_res, 32'd14);
    run_op(3'd7, 32'd100, 32'd7, "remu_100_7");
    chk("remu_100_7/const", last_res, 32'd2);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf/const", last_res, 32'h8000_0000);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    chk("rem_ovf/const", last_res, 32'd0);
    run_op(3'd4, 32'd5, 32'd0, "div_by0");
    chk("div_by0/const", last_res, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd5, 32'd0, "rem_by0");
    chk("rem_by0/const", last_res, 32'd5);
    run_op(3'd5, 32'd9, 32'd0, "divu_by0");
    run_op(3'd7, 32'd9, 32'd0, "remu_by0");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");

    // MULH aborted by flush in its tenth cycle
    mdop  = 3'd1;
    opr_a = 32'h8000_0000;
    opr_b = 32'h8000_0000;
    start = 1'b1;
    #1;
    chk("flush/issue_stall", 32'(stall), 32'd1);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    flush = 1'b1;
    #1;
    chk("flush/stall", 32'(stall), 32'd0);
    chk("flush/done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    n_done = 0;
    n_st   = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) n_done++;
      if (stall) n_st++;
      @(posedge clk);
      #2;
    end
    chk("flush/no_done", 32'(n_done), 32'd0);
    chk("flush/no_stall", 32'(n_st), 32'd0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'd2, "mulhu_after_flush");
    chk("mulhu_after_flush/const", last_res, 32'd1);

    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
    chk("mulhsu_m1/const", last_res, 32'hFFFF_FFFF);

    // Flush coincident with start must not launch the op
    mdop  = 3'd5;
    opr_a = 32'd100;
    opr_b = 32'd7;
    start = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_issue/stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    #1;
    chk("flush_issue/idle_stall", 32'(stall), 32'd0);
    chk("flush_issue/idle_done", 32'(done), 32'd0);
    @(posedge clk);
    #1;

    // Async reset in the middle of a divide
    mdop  = 3'd5;
    opr_a = 32'd1000;
    opr_b = 32'd3;
    start = 1'b1;
    #1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("areset/stall", 32'(stall), 32'd0);
    chk("areset/done", 32'(done), 32'd0);
    chk("areset/result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(3'd5, 32'd1000, 32'd3, "divu_after_reset");

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       a = 32'($urandom_range(0, 255));
        default: ;
      endcase
      run_op(op, a, b, $sformatf("rand%0d_op%0d", i, op));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Multi-cycle sequencer for RV32M multiply/divide ops issued from the execute stage.
- Accepts forwarded operands and an op code from EX, holds the pipeline via `stall` while iterating, then returns a one-cycle `done` with the result.
- Sits beside the single-cycle ALU; EX muxes `result` into `opr_res` when `done` is high.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and >= 8.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  op valid from EX (M-extension instruction present)
- mdop  in  3  op: funct3 encoding (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
- opr_a  in  DATA_WIDTH  forwarded rs1 value
- opr_b  in  DATA_WIDTH  forwarded rs2 value
- flush  in  1  pipeline flush; aborts op in flight
- stall  out  1  hold IF/ID/EX registers
- done  out  1  result valid, one cycle
- result  out  DATA_WIDTH  op result, valid only with done

Behaviour:
- Reset (rst_n low, async): state=IDLE, stall=0, done=0, result=0, counter=0, internal regs=0.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 and flush=0: latch operands, mdop, sign flags; go CALC, counter=0.
  - stall=start & ~flush combinationally in IDLE; the issuing instruction stalls from its first EX cycle.
- Special divide cases (IDLE, start=1): go directly to FIN, skipping CALC.
  - opr_b==0: DIV/DIVU quotient = all ones; REM/REMU = opr_a.
  - DIV/REM signed overflow (opr_a = 1<<(DATA_WIDTH-1), opr_b = all ones): quotient = opr_a, remainder = 0.
- CALC:
  - One radix-2 step per cycle; counter increments; stall=1.
  - After DATA_WIDTH steps (counter==DATA_WIDTH-1), go FIN.
- Multiply:
  - Shift-add on magnitudes with a 2*DATA_WIDTH product register.
  - Final negate when operand signs differ (MULH: both signed; MULHSU: a signed only).
  - MUL returns the low half; MULH* return the high half.
- Divide:
  - Restoring division on magnitudes.
  - Quotient negated when signs differ (DIV); remainder takes the dividend sign (REM).
- FIN: done=1, result driven from a registered value, stall=0; return to IDLE next cycle.
- Latency: DATA_WIDTH+1 cycles from start to done for normal ops; 1 cycle for special cases.
- start is ignored outside IDLE. A new start is accepted in the IDLE cycle right after FIN (back-to-back issue).
- flush has priority in every state:
  - Go IDLE next cycle; done stays 0; stall=0 in the flush cycle.
  - No result is produced for the aborted op.
- Async reset mid-CALC: immediate return to IDLE; all outputs 0.

Optional Feature:
- MDU_FAST_MUL_EN defined: MUL* ops compute with a combinational DATA_WIDTH x DATA_WIDTH multiplier in IDLE, go straight to FIN; latency 1 cycle. Divide behaviour is unchanged.
- MDU_FAST_MUL_EN undefined: MUL* use the iterative shift-add path; latency DATA_WIDTH+1 cycles.

Decomposition:
- mdu_pkg:
  - mdop_t enum (MUL=3'b000 … REMU=3'b111).
  - state_t enum {IDLE, CALC, FIN}.
  - Helper functions is_div(mdop_t) and is_signed_a/b(mdop_t).
- Sub-module mdu_iter: per-cycle shift-add/restoring-subtract datapath step, purely combinational on (acc, operand, mode). mdu_seq owns the FSM, counter, sign fixup, special cases and flush.

Test Plan:
- MUL, a=7, b=-3, no flush → stall high 33 cycles; done on cycle 33 with result 0xFFFFFFEB; stall low in the done cycle.
- DIVU, a=100, b=7 → result 14 at cycle 33. REMU with the same operands → result 2.
- DIV, a=0x80000000, b=0xFFFFFFFF → done the next cycle with result 0x80000000. REM with the same operands → result 0.
- DIV, b=0, a=5 → done the next cycle with result 0xFFFFFFFF. REM, b=0, a=5 → result 5.
- MULH, a=0x80000000, b=0x80000000; flush pulsed at cycle 10 → state returns IDLE, done never asserts, stall=0 from cycle 10. A fresh MULHU 0xFFFFFFFF×2 then returns 0x00000001.
- MDU_FAST_MUL_EN build: MULHSU, a=-1, b=0xFFFFFFFF → done after 1 cycle with result 0xFFFFFFFF. DIVU 100/7 still takes 33 cycles.
